pll_spi_master: RTL and testbench

//  SPI register-access engine for the clock-generator PLL. Consumes single-byte

---
 rtl/pll_spi_master_if.sv | 22 ++
 rtl/pll_spi_master.sv | 174 +++++++++++++++++
 tb/tb_pll_spi_master.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_spi_master_if.sv
// Command bus between the PLL bring-up sequencer and the SPI engine.
// master: sequencer side (drives cmd_*); slave: engine side (drives results).
interface pll_spi_master_if;
    logic       cmd_hold;
    logic       cmd_read;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic [7:0] cmd_rdata;
    logic       cmd_done;
    logic       busy;

    modport master (
        output cmd_hold, cmd_read, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_rdata, cmd_done, busy
    );

    modport slave (
        input  cmd_hold, cmd_read, cmd_write, cmd_addr, cmd_wdata,
        output cmd_rdata, cmd_done, busy
    );
endinterface

// File: rtl/pll_spi_master.sv
// SPI register-access engine for the clock-generator PLL (mode 0, MSB first,
// 16-bit frames). Each command becomes a set-address frame (0x00AA) followed
// by a write (0x40DD) or read (0x8000) frame.
// Ports: clk, reset (sync, active-high), cmd (pll_spi_master_if.slave:
//   hold/read/write/addr/wdata in, rdata/done/busy out), spi_sclk_o,
//   spi_csn_o, spi_mosi_o, spi_miso_i.
// Option: define PLL_SPI_ADDR_CACHE_EN to skip the set-address frame when
//   the address matches the last one sent.
module pll_spi_master #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input  logic              clk,
    input  logic              reset,
    pll_spi_master_if.slave   cmd,
    output logic              spi_sclk_o,
    output logic              spi_csn_o,
    output logic              spi_mosi_o,
    input  logic              spi_miso_i
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int GW = $clog2(CS_GAP + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    state_t         state_q;
    logic [7:0]     addr_q;
    logic [7:0]     wdata_q;
    logic [7:0]     rx_q;
    logic [7:0]     rdata_q;
    logic           wr_q;
    logic           fsel_q;
    logic           sclk_q;
    logic           csn_q;
    logic           mosi_q;
    logic           done_q;
    logic           busy_q;
    logic [3:0]     bit_q;
    logic [DW-1:0]  div_q;
    logic [GW-1:0]  gap_q;
`ifdef PLL_SPI_ADDR_CACHE_EN
    logic [7:0]     last_addr_q;
    logic           last_vld_q;
`endif

    // fsel_q: 0 = set-address frame, 1 = data frame
    logic [15:0] data_w;
    logic [15:0] frame_w;

    always_comb begin
        data_w  = wr_q ? {8'h40, wdata_q} : 16'h8000;
        frame_w = fsel_q ? data_w : {8'h00, addr_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            rx_q    <= 8'h00;
            rdata_q <= 8'h00;
            wr_q    <= 1'b0;
            fsel_q  <= 1'b0;
            sclk_q  <= 1'b0;
            csn_q   <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            bit_q   <= 4'd0;
            div_q   <= '0;
            gap_q   <= '0;
`ifdef PLL_SPI_ADDR_CACHE_EN
            last_addr_q <= 8'h00;
            last_vld_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!cmd.cmd_hold && (cmd.cmd_read || cmd.cmd_write)) begin
                        addr_q  <= cmd.cmd_addr;
                        wdata_q <= cmd.cmd_wdata;
                        wr_q    <= cmd.cmd_write;
                        busy_q  <= 1'b1;
                        csn_q   <= 1'b0;
                        sclk_q  <= 1'b0;
                        bit_q   <= 4'd0;
                        div_q   <= '0;
                        state_q <= SHIFT;
`ifdef PLL_SPI_ADDR_CACHE_EN
                        // Cache hit: go straight to the data frame, whose
                        // MSB is 1 for read and 0 for write.
                        if (last_vld_q && cmd.cmd_addr == last_addr_q) begin
                            fsel_q <= 1'b1;
                            mosi_q <= ~cmd.cmd_write;
                        end else begin
                            fsel_q <= 1'b0;
                            mosi_q <= 1'b0;
                        end
`else
                        fsel_q <= 1'b0;
                        mosi_q <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    if (div_q == DW'(CLK_DIV - 1)) begin
                        div_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                            rx_q   <= {rx_q[6:0], spi_miso_i};
                        end else if (bit_q == 4'd15) begin
                            sclk_q  <= 1'b0;
                            csn_q   <= 1'b1;
                            mosi_q  <= 1'b0;
                            gap_q   <= '0;
                            state_q <= GAP;
                            // rx_q holds the last 8 bits: the read data byte
                            if (fsel_q && !wr_q) begin
                                rdata_q <= rx_q;
                            end
`ifdef PLL_SPI_ADDR_CACHE_EN
                            if (!fsel_q) begin
                                last_addr_q <= addr_q;
                                last_vld_q  <= 1'b1;
                            end
`endif
                        end else begin
                            sclk_q <= 1'b0;
                            bit_q  <= bit_q + 4'd1;
                            mosi_q <= frame_w[4'd14 - bit_q];
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                GAP: begin
                    if (gap_q == GW'(CS_GAP - 1)) begin
                        if (!fsel_q) begin
                            fsel_q  <= 1'b1;
                            csn_q   <= 1'b0;
                            bit_q   <= 4'd0;
                            div_q   <= '0;
                            mosi_q  <= data_w[15];
                            state_q <= SHIFT;
                        end else begin
                            state_q <= DONE;
                        end
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                DONE: begin
                    // First DONE cycle raises done; hold is only looked at
                    // once busy has dropped.
                    if (!done_q) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end else if (cmd.cmd_hold) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign spi_sclk_o    = sclk_q;
    assign spi_csn_o     = csn_q;
    assign spi_mosi_o    = mosi_q;
    assign cmd.cmd_rdata = rdata_q;
    assign cmd.cmd_done  = done_q;
    assign cmd.busy      = busy_q;
endmodule

// File: tb/tb_pll_spi_master.sv
// Randomized scoreboard bench for pll_spi_master with a PLL register-file
// model on the SPI pins. Define PLL_SPI_ADDR_CACHE_EN to cover the cache.
module tb_pll_spi_master;
    localparam int D = 4;
    localparam int G = 4;

    typedef struct {
        logic [7:0] rdata;
        int         due;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    logic sclk, csn, mosi, miso;

    always #5 clk = ~clk;

    pll_spi_master_if ifc();

    pll_spi_master #(.CLK_DIV(D), .CS_GAP(G)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd       (ifc.slave),
        .spi_sclk_o(sclk),
        .spi_csn_o (csn),
        .spi_mosi_o(mosi),
        .spi_miso_i(miso)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    logic [15:0] exp_frames[$];
    res_t        exp_res[$];

    // Reference model state
    logic [7:0] ref_mem[256];
    logic [7:0] exp_rd;
    bit         c_vld;
    logic [7:0] c_addr;

    // PLL slave model state
    logic [7:0] smem[256];
    logic [7:0] s_addr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name,
                         input int act, input int exp);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Frame monitor and PLL slave model
    logic        psclk = 1'b0;
    logic        pcsn = 1'b1;
    bit          in_frame = 0;
    int          nb = 0;
    int          lowc = 0;
    logic [15:0] word = '0;

    initial miso = 1'b0;

    always @(negedge clk) begin
        logic [15:0] e;
        logic [15:0] txw;
        if (reset) begin
            in_frame = 0;
        end else begin
            if (pcsn && !csn) begin
                in_frame = 1;
                nb = 0;
                lowc = 0;
                word = '0;
            end
            if (in_frame && !csn) begin
                lowc++;
                if (sclk && !psclk) begin
                    word = {word[14:0], mosi};
                    nb++;
                end
            end
            if (in_frame && csn) begin
                in_frame = 0;
                if (exp_frames.size() == 0) begin
                    check(0, "frame_unexpected", int'(word), 0);
                end else begin
                    e = exp_frames.pop_front();
                    check(word == e, "frame_word", int'(word), int'(e));
                    check(nb == 16 && lowc == 32 * D, "frame_len",
                          lowc, 32 * D);
                end
                if (nb == 16) begin
                    if (word[15:8] == 8'h00) s_addr = word[7:0];
                    else if (word[15:8] == 8'h40) smem[s_addr] = word[7:0];
                end
            end
        end
        psclk = sclk;
        pcsn = csn;
        txw = {8'h00, smem[s_addr]};
        miso = (in_frame && !csn && nb < 16) ? txw[15 - nb] : 1'b0;
    end

    // Completion monitor
    logic pdone = 1'b0;

    always @(negedge clk) begin
        res_t r;
        if (!reset && ifc.cmd_done && !pdone) begin
            if (exp_res.size() == 0) begin
                check(0, "done_unexpected", 1, 0);
            end else begin
                r = exp_res.pop_front();
                check(ifc.cmd_rdata == r.rdata, "rdata",
                      int'(ifc.cmd_rdata), int'(r.rdata));
                check(cyc == r.due, "latency", cyc, r.due);
                check(!ifc.busy, "busy_at_done", int'(ifc.busy), 0);
            end
        end
        pdone = reset ? 1'b0 : ifc.cmd_done;
    end

    task automatic do_cmd(input bit rd, input bit wr,
                          input logic [7:0] a, input logic [7:0] d);
        int   nfr;
        int   acc;
        int   t;
        int   k;
        res_t r;
        @(negedge clk);
        ifc.cmd_hold  = 1'b0;
        ifc.cmd_read  = rd;
        ifc.cmd_write = wr;
        ifc.cmd_addr  = a;
        ifc.cmd_wdata = d;
        acc = cyc + 1;
        nfr = 2;
`ifdef PLL_SPI_ADDR_CACHE_EN
        if (c_vld && c_addr == a) nfr = 1;
        c_vld  = 1;
        c_addr = a;
`endif
        if (nfr == 2) exp_frames.push_back({8'h00, a});
        if (wr) begin
            exp_frames.push_back({8'h40, d});
            ref_mem[a] = d;
        end else begin
            exp_frames.push_back(16'h8000);
            exp_rd = ref_mem[a];
        end
        r.rdata = exp_rd;
        r.due = acc + nfr * (32 * D + G) + 1;
        exp_res.push_back(r);
        t = 0;
        while (!ifc.cmd_done && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!ifc.cmd_done) begin
            check(0, "done_timeout", t, 3000);
            return;
        end
        // Done must hold with hold low, and no new frame may start
        k = $urandom_range(1, 4);
        repeat (k) begin
            ifc.cmd_read  = 1'($urandom);
            ifc.cmd_write = 1'($urandom);
            ifc.cmd_addr  = 8'($urandom);
            @(negedge clk);
            check(ifc.cmd_done && csn, "done_hold",
                  int'({ifc.cmd_done, csn}), 3);
        end
        ifc.cmd_hold = 1'b1;
        @(negedge clk);
        check(!ifc.cmd_done, "done_clear", int'(ifc.cmd_done), 0);
        ifc.cmd_read  = 1'b0;
        ifc.cmd_write = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        for (int i = 0; i < 256; i++) begin
            smem[i] = 8'($urandom);
        end
        smem[2] = 8'hA5;
        for (int i = 0; i < 256; i++) ref_mem[i] = smem[i];
        s_addr = 8'h00;
        exp_rd = 8'h00;
        c_vld  = 0;
        c_addr = 8'h00;

        reset = 1'b1;
        ifc.cmd_hold  = 1'b1;
        ifc.cmd_read  = 1'b0;
        ifc.cmd_write = 1'b0;
        ifc.cmd_addr  = 8'h00;
        ifc.cmd_wdata = 8'h00;
        repeat (3) @(negedge clk);
        check(csn && !sclk && !mosi, "reset_pins",
              int'({csn, sclk, mosi}), 4);
        check(!ifc.cmd_done && !ifc.busy, "reset_status",
              int'({ifc.cmd_done, ifc.busy}), 0);
        check(ifc.cmd_rdata == 8'h00, "reset_rdata",
              int'(ifc.cmd_rdata), 0);
        reset = 1'b0;

        // Directed: write, read of 0xA5, read+write together
        do_cmd(1'b0, 1'b1, 8'h43, 8'h01);
        do_cmd(1'b1, 1'b0, 8'h02, 8'h00);
        do_cmd(1'b1, 1'b1, 8'h05, 8'h3C);

        // Neither request high: nothing must happen
        @(negedge clk);
        ifc.cmd_hold = 1'b0;
        repeat (10) @(negedge clk);
        check(csn && !ifc.busy, "no_request_idle",
              int'({csn, ifc.busy}), 2);
        ifc.cmd_hold = 1'b1;

`ifdef PLL_SPI_ADDR_CACHE_EN
        do_cmd(1'b1, 1'b0, 8'h03, 8'h00);
        do_cmd(1'b1, 1'b0, 8'h03, 8'h00);
`endif

        // Reset during bit 7 of frame 1
        @(negedge clk);
        ifc.cmd_hold  = 1'b0;
        ifc.cmd_write = 1'b1;
        ifc.cmd_addr  = 8'h11;
        ifc.cmd_wdata = 8'h77;
        t = 0;
        while (!(in_frame && nb >= 8) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check(in_frame && nb >= 8, "abort_reach_bit7", nb, 8);
        reset = 1'b1;
        ifc.cmd_hold  = 1'b1;
        ifc.cmd_write = 1'b0;
        @(negedge clk);
        check(csn && !sclk && !ifc.cmd_done && !ifc.busy, "abort_state",
              int'({csn, sclk, ifc.cmd_done, ifc.busy}), 8);
        reset = 1'b0;
        exp_frames.delete();
        exp_res.delete();
        exp_rd = 8'h00;
        c_vld  = 0;
        @(negedge clk);
        do_cmd(1'b0, 1'b1, 8'h12, 8'h9E);

`ifdef PLL_SPI_ADDR_CACHE_EN
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_rd = 8'h00;
        c_vld  = 0;
        do_cmd(1'b1, 1'b0, 8'h03, 8'h00);
`endif

        // Randomized commands over a small address window
        for (int n = 0; n < 24; n++) begin
            int op;
            op = $urandom_range(0, 2);
            do_cmd(op != 1, op != 0, 8'($urandom_range(0, 7)),
                   8'($urandom));
        end

        repeat (5) @(negedge clk);
        check(exp_frames.size() == 0 && exp_res.size() == 0,
              "queues_drained", exp_frames.size() + exp_res.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
